// File: rtl/drum_store_pkg.sv
// Shared definitions for the drum store: FSM state encoding, op encoding and default sizes.
package drum_store_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 31;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEEK    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/drum_store_sector_counter.sv
// Free-running drum position: div counts clocks within a sector, sector advances on each div wrap.
module drum_sector_counter #(
    parameter int ADDR_W        = 12,
    parameter int SECTOR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] sector
);

    localparam int DIV_W = (SECTOR_CYCLES > 1) ? $clog2(SECTOR_CYCLES) : 1;

    logic [DIV_W-1:0]  div_reg;
    logic [ADDR_W-1:0] sector_reg;
    logic              div_wrap;

    assign div_wrap = (div_reg == DIV_W'(SECTOR_CYCLES - 1));
    assign sector   = sector_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_reg    <= '0;
            sector_reg <= '0;
        end else if (div_wrap) begin
            div_reg    <= '0;
            sector_reg <= sector_reg + ADDR_W'(1);
        end else begin
            div_reg    <= div_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/drum_store.sv
// Drum store responder: one read/write per request, single-cycle finish, optional rotational wait.
// Build option: define DRUM_LATENCY_EN to compile in the sector counter and SEEK state.
module drum_store
    import drum_store_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SECTOR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              write_enable,
    input  logic              read_enable,
    output logic              finish,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_reg, state_next;
    op_t               op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              finish_reg, finish_next;
    logic [DATA_W-1:0] read_data_reg;
    logic              request;
    logic              latch_en;
    logic              access_en;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    if (SECTOR_CYCLES < 1) begin : g_bad_sector_cycles
        $error("SECTOR_CYCLES must be at least 1");
    end

    assign request   = write_enable | read_enable;
    assign finish    = finish_reg;
    assign read_data = read_data_reg;

`ifdef DRUM_LATENCY_EN
    logic [ADDR_W-1:0] sector;

    drum_sector_counter #(
        .ADDR_W        (ADDR_W),
        .SECTOR_CYCLES (SECTOR_CYCLES)
    ) u_sector_counter (
        .clk    (clk),
        .resetn (resetn),
        .sector (sector)
    );
`endif

    always_comb begin
        state_next  = state_reg;
        finish_next = 1'b0;
        latch_en    = 1'b0;
        access_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (request) begin
                    latch_en = 1'b1;
`ifdef DRUM_LATENCY_EN
                    state_next = ST_SEEK;
`else
                    state_next = ST_ACCESS;
`endif
                end
            end
`ifdef DRUM_LATENCY_EN
            ST_SEEK: begin
                if (sector == addr_reg) begin
                    state_next = ST_ACCESS;
                end
            end
`endif
            ST_ACCESS: begin
                access_en   = 1'b1;
                finish_next = 1'b1;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Hold off until the initiator has dropped both enables, so a lingering request is not re-run.
                if (!request) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            finish_reg    <= 1'b0;
            read_data_reg <= '0;
            op_reg        <= OP_READ;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            finish_reg <= finish_next;
            if (latch_en) begin
                op_reg    <= write_enable ? OP_WRITE : OP_READ;
                addr_reg  <= addr;
                wdata_reg <= write_data;
            end
            if (access_en && (op_reg == OP_READ)) begin
                read_data_reg <= mem[addr_reg];
            end
        end
    end

    // Array has no reset so it maps onto block RAM; contents survive resetn.
    always_ff @(posedge clk) begin
        if (access_en && (op_reg == OP_WRITE)) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

endmodule
